// File: rtl/shift_reg_var_delay.sv
// Valid-gated delay line with a runtime-selectable output tap (0..MaxDepth),
// global stall, flush and an occupancy count over all physical stages.

module shift_reg_var_delay_stage #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             v_in,
    input  logic [Width-1:0] d_in,
    output logic             v_q,
    output logic [Width-1:0] d_q
);

    // Data only moves behind a valid item, so bubbles leave the last payload parked.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else if (flush_i) begin
            v_q <= 1'b0;
        end else if (en_i) begin
            v_q <= v_in;
            if (v_in) d_q <= d_in;
        end
    end

endmodule

module shift_reg_var_delay #(
    parameter  int Width    = 32,
    parameter  int MaxDepth = 8,
    localparam int DepthW   = $clog2(MaxDepth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic [DepthW-1:0] depth_i,
    input  logic              valid_i,
    input  logic [Width-1:0]  data_i,
    output logic              valid_o,
    output logic [Width-1:0]  data_o,
    output logic [DepthW-1:0] count_o,
    output logic              depth_err_o
);

    localparam logic [DepthW-1:0] MaxDepthD = DepthW'(MaxDepth);

    // Index 0 is the live input; index k is physical stage k.
    logic [MaxDepth:0]            vld_pipe;
    logic [MaxDepth:0][Width-1:0] dat_pipe;
    logic [DepthW-1:0]            de;
    logic [DepthW-1:0]            cnt;

    assign vld_pipe[0] = valid_i;
    assign dat_pipe[0] = data_i;

    for (genvar k = 1; k <= MaxDepth; k++) begin : g_stage
        shift_reg_var_delay_stage #(.Width(Width)) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (en_i),
            .flush_i (flush_i),
            .v_in    (vld_pipe[k-1]),
            .d_in    (dat_pipe[k-1]),
            .v_q     (vld_pipe[k]),
            .d_q     (dat_pipe[k])
        );
    end

    assign depth_err_o = (depth_i > MaxDepthD);
    assign de          = depth_err_o ? MaxDepthD : depth_i;

    // Tap 0 bypasses the registers but still honours stall, flush and reset.
    always_comb begin
        valid_o = 1'b0;
        data_o  = data_i;
        if (de == '0) begin
            valid_o = valid_i & en_i & ~flush_i & ~rst_i;
        end else begin
            valid_o = vld_pipe[de];
            data_o  = dat_pipe[de];
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 1; k <= MaxDepth; k++) cnt = cnt + DepthW'(vld_pipe[k]);
    end

    assign count_o = cnt;

endmodule
